sb_interconnect: RTL and testbench

SB_INTERCONNECT -- requirements
Module: sb_interconnect

---
 rtl/sb_pkg.sv | 38 +++
 rtl/sb_rr_arbiter.sv | 45 ++++
 rtl/sb_interconnect.sv | 172 +++++++++++++++++
 tb/tb_sb_interconnect.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sb_pkg.sv
// -----------------------------------------------------------------------------
// sb_pkg -- shared definitions for the system-bus interconnect.
//   * sb_state_e       : transaction FSM states
//   * sb_cmd_t         : command latched from the winning master
//   * DEAD_BEEF        : read data returned with an error completion
//   * SLOT_MSB/LSB     : address field that selects the slave slot
//   * DEFAULT_SLV_MASK : populated slots (0 data_mem, 3 ps2, 7 vga)
// -----------------------------------------------------------------------------
package sb_pkg;

   localparam int N_MST = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_RESP,
      ST_ERR
   } sb_state_e;

   typedef struct packed {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wd;
   } sb_cmd_t;

   localparam logic [31:0] DEAD_BEEF        = 32'hDEAD_BEEF;
   localparam int          SLOT_MSB         = 31;
   localparam int          SLOT_LSB         = 24;
   localparam logic [7:0]  DEFAULT_SLV_MASK = 8'h89;
   localparam int          TMO_W            = 5;

   function automatic logic [7:0] slot_of(input logic [31:0] addr);
      return addr[SLOT_MSB:SLOT_LSB];
   endfunction

endpackage

// File: rtl/sb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// sb_rr_arbiter -- two-requester round-robin arbiter.
//   clk_i, resetn_i : system clock, asynchronous active-low reset
//   req             : request vector, one bit per master
//   done            : a transaction has completed this cycle
//   done_idx        : index of the master whose transaction completed
//   grant           : one-hot grant (all zero when nobody requests)
// The pointer names the master with priority; it starts at master 0 and
// moves to the other master whenever a transaction completes.
// -----------------------------------------------------------------------------
module sb_rr_arbiter
   import sb_pkg::*;
(
   input  logic             clk_i,
   input  logic             resetn_i,
   input  logic [N_MST-1:0] req,
   input  logic             done,
   input  logic             done_idx,
   output logic [N_MST-1:0] grant
);

   logic ptr_q;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the values that existed before the clock edge.
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         ptr_q <= 1'b0;
      end else if (done) begin
         ptr_q <= ~done_idx;
      end
   end

   // NOTE: the default assignment comes first so every path through the
   // block assigns grant; otherwise a latch would be inferred.
   always_comb begin
      grant = '0;
      if (req[ptr_q]) begin
         grant[ptr_q] = 1'b1;
      end else if (req[~ptr_q]) begin
         grant[~ptr_q] = 1'b1;
      end
   end

endmodule

// File: rtl/sb_interconnect.sv
// -----------------------------------------------------------------------------
// sb_interconnect -- two masters (m0 = LSU, m1 = loader) to N_SLV slave slots.
// The slot is taken from addr[31:24]; slaves see {8'h0, addr[23:0]}.
//   clk_i, resetn_i          : system clock, asynchronous active-low reset
//   m_req_i, m_we_i          : per-master request / write
//   m_be_i, m_addr_i, m_wd_i : per-master byte enables, address, write data
//   m_ready_o, m_err_o       : per-master completion pulse / error qualifier
//   m_rd_o                   : shared read data, valid with m_ready_o
//   s_req_o                  : one-hot slave request (single cycle)
//   s_we_o, s_be_o,
//   s_addr_o, s_wd_o         : shared slave command bus
//   s_rd_i, s_ready_i        : per-slave read data and ready
// Every output comes straight from a flop.
// Timing: request in cycle 0 -> s_req_o in cycle 1 -> ready sampled in
// cycle 2 -> m_ready_o in cycle 3. Unmapped slots complete in cycle 2.
// -----------------------------------------------------------------------------
module sb_interconnect
   import sb_pkg::*;
#(
   parameter int               N_SLV    = 8,
   parameter logic [N_SLV-1:0] SLV_MASK = N_SLV'(DEFAULT_SLV_MASK),
   parameter int               TIMEOUT  = 15
) (
   input  logic                        clk_i,
   input  logic                        resetn_i,
   input  logic [N_MST-1:0]            m_req_i,
   input  logic [N_MST-1:0]            m_we_i,
   input  logic [N_MST-1:0][3:0]       m_be_i,
   input  logic [N_MST-1:0][31:0]      m_addr_i,
   input  logic [N_MST-1:0][31:0]      m_wd_i,
   output logic [N_MST-1:0]            m_ready_o,
   output logic [N_MST-1:0]            m_err_o,
   output logic [31:0]                 m_rd_o,
   output logic [N_SLV-1:0]            s_req_o,
   output logic                        s_we_o,
   output logic [3:0]                  s_be_o,
   output logic [31:0]                 s_addr_o,
   output logic [31:0]                 s_wd_o,
   input  logic [N_SLV-1:0][31:0]      s_rd_i,
   input  logic [N_SLV-1:0]            s_ready_i
);

   localparam int               SLOT_W    = (N_SLV > 1) ? $clog2(N_SLV) : 1;
   localparam logic [255:0]     MASK_EXT  = 256'(SLV_MASK);
   localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT);

   sb_state_e         state_q, state_d;
   sb_cmd_t           cmd_q;
   logic [SLOT_W-1:0] slot_q;
   logic              gnt_q;
   logic [TMO_W-1:0]  tmo_q, tmo_next;

   logic [N_MST-1:0]  arb_gnt;
   logic              arb_idx;
   logic              accept, take, win_mapped, ready_hit, done;
   logic [7:0]        win_slot;
   logic [SLOT_W-1:0] win_slot_w;

   logic [N_SLV-1:0]  s_req_d;
   logic [N_MST-1:0]  m_ready_d, m_err_d;
   logic [31:0]       m_rd_d;

   sb_rr_arbiter u_arb (
      .clk_i    (clk_i),
      .resetn_i (resetn_i),
      .req      (m_req_i),
      .done     (done),
      .done_idx (gnt_q),
      .grant    (arb_gnt)
   );

   // An error pulse is still on the outputs during the first IDLE cycle after
   // ERR; the master's request is legitimately still high then, so hold off
   // arbitration until the pulse has gone.
   assign accept     = (state_q == ST_IDLE) && (m_ready_o == '0);
   assign take       = accept && (|m_req_i);
   assign arb_idx    = arb_gnt[1];
   assign win_slot   = slot_of(m_addr_i[arb_idx]);
   assign win_slot_w = SLOT_W'(win_slot);
   assign win_mapped = (int'(win_slot) < N_SLV) && MASK_EXT[win_slot];
   assign ready_hit  = s_ready_i[slot_q];
   assign tmo_next   = tmo_q + TMO_W'(1);
   assign done       = ((state_q == ST_WAIT) && ready_hit) || (state_q == ST_ERR);

   // Shared slave bus: held from the grant until the next grant.
   assign s_we_o   = cmd_q.we;
   assign s_be_o   = cmd_q.be;
   assign s_addr_o = cmd_q.addr;
   assign s_wd_o   = cmd_q.wd;

   // State register
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; s_ready_i only matters in WAIT.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (take) state_d = win_mapped ? ST_REQ : ST_ERR;
         ST_REQ:  state_d = ST_WAIT;
         ST_WAIT: begin
            if (ready_hit) begin
               state_d = ST_RESP;
            end else if (tmo_next == TMO_LIMIT) begin
               state_d = ST_ERR;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         ST_ERR:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Output logic: values the output flops take at the next edge, so each
   // pulse is visible in the cycle the FSM names it for (REQ, RESP) or, for
   // ERR, in the cycle after the error is decided.
   always_comb begin
      s_req_d   = '0;
      m_ready_d = '0;
      m_err_d   = '0;
      m_rd_d    = '0;
      unique case (state_q)
         ST_IDLE: if (take && win_mapped) s_req_d[win_slot_w] = 1'b1;
         ST_WAIT: begin
            if (ready_hit) begin
               m_ready_d[gnt_q] = 1'b1;
               m_rd_d           = cmd_q.we ? 32'h0 : s_rd_i[slot_q];
            end
         end
         ST_ERR: begin
            m_ready_d[gnt_q] = 1'b1;
            m_err_d[gnt_q]   = 1'b1;
            m_rd_d           = DEAD_BEEF;
         end
         default: ;
      endcase
   end

   // Output flops and transaction datapath
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         s_req_o   <= '0;
         m_ready_o <= '0;
         m_err_o   <= '0;
         m_rd_o    <= '0;
         cmd_q     <= '0;
         slot_q    <= '0;
         gnt_q     <= 1'b0;
         tmo_q     <= '0;
      end else begin
         s_req_o   <= s_req_d;
         m_ready_o <= m_ready_d;
         m_err_o   <= m_err_d;
         m_rd_o    <= m_rd_d;
         if (take) begin
            gnt_q  <= arb_idx;
            slot_q <= win_slot_w;
            cmd_q  <= '{we:   m_we_i[arb_idx],
                        be:   m_be_i[arb_idx],
                        addr: {8'h00, m_addr_i[arb_idx][23:0]},
                        wd:   m_wd_i[arb_idx]};
         end
         tmo_q <= (state_q == ST_WAIT) ? tmo_next : '0;
      end
   end

endmodule

// File: tb/tb_sb_interconnect.sv
// -----------------------------------------------------------------------------
// tb_sb_interconnect -- directed bench for sb_interconnect.
// Slots 0 and 3 answer one cycle after their request; slot 7 never answers.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. Cycle 0 is the cycle in which a request is raised.
// -----------------------------------------------------------------------------
module tb_sb_interconnect;

   logic                 clk = 1'b0;
   logic                 resetn_i;
   logic [1:0]           m_req_i, m_we_i;
   logic [1:0][3:0]      m_be_i;
   logic [1:0][31:0]     m_addr_i, m_wd_i;
   logic [1:0]           m_ready_o, m_err_o;
   logic [31:0]          m_rd_o;
   logic [7:0]           s_req_o;
   logic                 s_we_o;
   logic [3:0]           s_be_o;
   logic [31:0]          s_addr_o, s_wd_o;
   logic [7:0][31:0]     s_rd_i;
   logic [7:0]           s_ready_i;

   int n_checks;
   int n_fail;

   typedef struct {
      int          lat;
      logic [1:0]  rdy;
      logic [1:0]  err;
      logic [31:0] rd;
      int          nsreq;
      logic [7:0]  sreq;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wd;
   } obs_t;

   sb_interconnect dut (
      .clk_i     (clk),
      .resetn_i  (resetn_i),
      .m_req_i   (m_req_i),
      .m_we_i    (m_we_i),
      .m_be_i    (m_be_i),
      .m_addr_i  (m_addr_i),
      .m_wd_i    (m_wd_i),
      .m_ready_o (m_ready_o),
      .m_err_o   (m_err_o),
      .m_rd_o    (m_rd_o),
      .s_req_o   (s_req_o),
      .s_we_o    (s_we_o),
      .s_be_o    (s_be_o),
      .s_addr_o  (s_addr_o),
      .s_wd_o    (s_wd_o),
      .s_rd_i    (s_rd_i),
      .s_ready_i (s_ready_i)
   );

   always #5 clk = ~clk;

   // Slave responder: a slot enabled in resp_en raises ready for one cycle,
   // the cycle after it saw its request. Data is garbage when not ready.
   logic [7:0]  resp_en;
   logic [7:0]  req_seen;
   logic [31:0] slot_data [8];

   always begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 8; k++) begin
         s_ready_i[k] = req_seen[k] && resp_en[k];
         s_rd_i[k]    = s_ready_i[k] ? slot_data[k] : (32'hBAD0_0000 | 32'(k));
      end
      req_seen = s_req_o;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int m, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wd);
      m_we_i[m]   = we;
      m_be_i[m]   = be;
      m_addr_i[m] = addr;
      m_wd_i[m]   = wd;
      m_req_i[m]  = 1'b1;
   endtask

   // Called in cycle 0; returns on the falling edge of the completion cycle.
   // lat stays -1 if no completion arrives within the budget.
   task automatic wait_done(input int budget, output obs_t o);
      o = '{lat: -1, rdy: 2'b00, err: 2'b00, rd: 32'h0, nsreq: 0, sreq: 8'h00,
            we: 1'b0, be: 4'h0, addr: 32'h0, wd: 32'h0};
      for (int c = 0; c <= budget; c++) begin
         @(negedge clk);
         if (s_req_o != 8'h00) begin
            o.nsreq++;
            o.sreq = s_req_o;
            o.we   = s_we_o;
            o.be   = s_be_o;
            o.addr = s_addr_o;
            o.wd   = s_wd_o;
         end
         if (m_ready_o != 2'b00) begin
            o.lat = c;
            o.rdy = m_ready_o;
            o.err = m_err_o;
            o.rd  = m_rd_o;
            break;
         end
         if (c < budget) step();
      end
   endtask

   task automatic test_reset();
      resetn_i = 1'b0;
      repeat (2) step();
      n_checks++; if (m_ready_o !== 2'b00 || m_err_o !== 2'b00) begin n_fail++; $display("FAIL reset_m_flags: ready=%b err=%b expected 00 00", m_ready_o, m_err_o); end
      n_checks++; if (m_rd_o !== 32'h0) begin n_fail++; $display("FAIL reset_m_rd: got %h expected 00000000", m_rd_o); end
      n_checks++; if (s_req_o !== 8'h00) begin n_fail++; $display("FAIL reset_s_req: got %h expected 00", s_req_o); end
      n_checks++; if ({s_we_o, s_be_o, s_addr_o, s_wd_o} !== 69'h0) begin n_fail++; $display("FAIL reset_s_bus: we=%b be=%h addr=%h wd=%h expected all 0", s_we_o, s_be_o, s_addr_o, s_wd_o); end
      resetn_i = 1'b1;
      step();
   endtask

   task automatic test_rr_pair();
      obs_t o;
      for (int pass = 0; pass < 2; pass++) begin
         drive(0, 1'b0, 4'hF, 32'h0000_0020, 32'h0);
         drive(1, 1'b0, 4'hF, 32'h0300_0040, 32'h0);
         wait_done(10, o);
         n_checks++; if (o.rdy !== 2'b01 || o.lat !== 3) begin n_fail++; $display("FAIL rr_pair%0d_first: ready=%b lat=%0d expected 01 3", pass, o.rdy, o.lat); end
         n_checks++; if (o.rd !== 32'h1234_5678) begin n_fail++; $display("FAIL rr_pair%0d_first_rd: got %h expected 12345678", pass, o.rd); end
         step();
         m_req_i[0] = 1'b0;
         wait_done(10, o);
         n_checks++; if (o.rdy !== 2'b10 || o.lat !== 3) begin n_fail++; $display("FAIL rr_pair%0d_second: ready=%b lat=%0d expected 10 3", pass, o.rdy, o.lat); end
         n_checks++; if (o.rd !== 32'hCAFE_0003) begin n_fail++; $display("FAIL rr_pair%0d_second_rd: got %h expected cafe0003", pass, o.rd); end
         step();
         m_req_i[1] = 1'b0;
      end
   endtask

   task automatic test_read();
      obs_t o;
      drive(0, 1'b0, 4'hF, 32'h0000_0010, 32'h0);
      wait_done(10, o);
      n_checks++; if (o.lat !== 3) begin n_fail++; $display("FAIL read_latency: got %0d expected 3", o.lat); end
      n_checks++; if (o.rdy !== 2'b01 || o.err !== 2'b00) begin n_fail++; $display("FAIL read_flags: ready=%b err=%b expected 01 00", o.rdy, o.err); end
      n_checks++; if (o.rd !== 32'h1234_5678) begin n_fail++; $display("FAIL read_data: got %h expected 12345678", o.rd); end
      n_checks++; if (o.nsreq !== 1 || o.sreq !== 8'h01) begin n_fail++; $display("FAIL read_s_req: cycles=%0d value=%h expected 1 01", o.nsreq, o.sreq); end
      n_checks++; if (o.addr !== 32'h0000_0010) begin n_fail++; $display("FAIL read_s_addr: got %h expected 00000010", o.addr); end
      step();
      m_req_i[0] = 1'b0;
      @(negedge clk);
      n_checks++; if (m_ready_o !== 2'b00 || m_rd_o !== 32'h0) begin n_fail++; $display("FAIL read_after: ready=%b rd=%h expected 00 00000000", m_ready_o, m_rd_o); end
      step();
   endtask

   task automatic test_write();
      obs_t o;
      drive(1, 1'b1, 4'b0011, 32'h0300_0004, 32'hA5A5_5A5A);
      wait_done(10, o);
      n_checks++; if (o.nsreq !== 1 || o.sreq !== 8'h08) begin n_fail++; $display("FAIL write_s_req: cycles=%0d value=%h expected 1 08", o.nsreq, o.sreq); end
      n_checks++; if (o.we !== 1'b1 || o.be !== 4'b0011) begin n_fail++; $display("FAIL write_s_we_be: we=%b be=%b expected 1 0011", o.we, o.be); end
      n_checks++; if (o.addr !== 32'h0000_0004 || o.wd !== 32'hA5A5_5A5A) begin n_fail++; $display("FAIL write_s_addr_wd: addr=%h wd=%h expected 00000004 a5a55a5a", o.addr, o.wd); end
      n_checks++; if (o.lat !== 3 || o.rdy !== 2'b10 || o.err !== 2'b00) begin n_fail++; $display("FAIL write_done: lat=%0d ready=%b err=%b expected 3 10 00", o.lat, o.rdy, o.err); end
      n_checks++; if (o.rd !== 32'h0) begin n_fail++; $display("FAIL write_rd: got %h expected 00000000", o.rd); end
      step();
      m_req_i[1] = 1'b0;
   endtask

   task automatic test_unmapped();
      obs_t o;
      logic quiet;
      drive(0, 1'b0, 4'hF, 32'h0500_0000, 32'h0);
      wait_done(10, o);
      n_checks++; if (o.lat !== 2) begin n_fail++; $display("FAIL unmapped_latency: got %0d expected 2", o.lat); end
      n_checks++; if (o.nsreq !== 0) begin n_fail++; $display("FAIL unmapped_s_req: cycles=%0d expected 0", o.nsreq); end
      n_checks++; if (o.rdy !== 2'b01 || o.err !== 2'b01) begin n_fail++; $display("FAIL unmapped_flags: ready=%b err=%b expected 01 01", o.rdy, o.err); end
      n_checks++; if (o.rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL unmapped_rd: got %h expected deadbeef", o.rd); end
      step();
      m_req_i[0] = 1'b0;
      quiet = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (m_ready_o != 2'b00 || s_req_o != 8'h00) quiet = 1'b0;
         step();
      end
      n_checks++; if (quiet !== 1'b1) begin n_fail++; $display("FAIL unmapped_no_repeat: activity=%b expected 0", ~quiet); end
   endtask

   task automatic test_timeout();
      obs_t o;
      drive(1, 1'b0, 4'hF, 32'h0700_0000, 32'h0);
      wait_done(30, o);
      n_checks++; if (o.nsreq !== 1 || o.sreq !== 8'h80) begin n_fail++; $display("FAIL timeout_s_req: cycles=%0d value=%h expected 1 80", o.nsreq, o.sreq); end
      n_checks++; if (o.lat !== 18) begin n_fail++; $display("FAIL timeout_latency: got %0d expected 18", o.lat); end
      n_checks++; if (o.rdy !== 2'b10 || o.err !== 2'b10 || o.rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL timeout_flags: ready=%b err=%b rd=%h expected 10 10 deadbeef", o.rdy, o.err, o.rd); end
      step();
      m_req_i[1] = 1'b0;
      drive(0, 1'b0, 4'hF, 32'h0000_0008, 32'h0);
      wait_done(10, o);
      n_checks++; if (o.lat !== 3 || o.rdy !== 2'b01 || o.err !== 2'b00 || o.rd !== 32'h1234_5678) begin n_fail++; $display("FAIL timeout_recover: lat=%0d ready=%b err=%b rd=%h expected 3 01 00 12345678", o.lat, o.rdy, o.err, o.rd); end
      step();
      m_req_i[0] = 1'b0;
   endtask

   // m0 completes, keeps requesting while m1 joins: m1 now has priority.
   task automatic test_back_to_back();
      obs_t o;
      drive(0, 1'b0, 4'hF, 32'h0000_0030, 32'h0);
      wait_done(10, o);
      n_checks++; if (o.rdy !== 2'b01 || o.lat !== 3) begin n_fail++; $display("FAIL b2b_first: ready=%b lat=%0d expected 01 3", o.rdy, o.lat); end
      step();
      drive(1, 1'b0, 4'hF, 32'h0300_0000, 32'h0);
      wait_done(10, o);
      n_checks++; if (o.rdy !== 2'b10 || o.rd !== 32'hCAFE_0003) begin n_fail++; $display("FAIL b2b_second: ready=%b rd=%h expected 10 cafe0003", o.rdy, o.rd); end
      step();
      m_req_i[1] = 1'b0;
      wait_done(10, o);
      n_checks++; if (o.rdy !== 2'b01 || o.lat !== 3) begin n_fail++; $display("FAIL b2b_third: ready=%b lat=%0d expected 01 3", o.rdy, o.lat); end
      step();
      m_req_i[0] = 1'b0;
   endtask

   task automatic test_reset_mid();
      obs_t o;
      logic quiet;
      drive(1, 1'b0, 4'hF, 32'h0700_0010, 32'h0);
      repeat (3) step();
      resetn_i = 1'b0;
      #1;
      n_checks++; if (m_ready_o !== 2'b00 || m_err_o !== 2'b00 || m_rd_o !== 32'h0) begin n_fail++; $display("FAIL midreset_m_out: ready=%b err=%b rd=%h expected 00 00 00000000", m_ready_o, m_err_o, m_rd_o); end
      n_checks++; if (s_req_o !== 8'h00 || {s_we_o, s_be_o, s_addr_o, s_wd_o} !== 69'h0) begin n_fail++; $display("FAIL midreset_s_out: req=%h be=%h addr=%h wd=%h expected all 0", s_req_o, s_be_o, s_addr_o, s_wd_o); end
      m_req_i = 2'b00;
      repeat (2) step();
      resetn_i = 1'b1;
      quiet = 1'b1;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         if (m_ready_o != 2'b00 || s_req_o != 8'h00) quiet = 1'b0;
         step();
      end
      n_checks++; if (quiet !== 1'b1) begin n_fail++; $display("FAIL midreset_stray: activity=%b expected 0", ~quiet); end
      drive(0, 1'b0, 4'hF, 32'h0000_0000, 32'h0);
      drive(1, 1'b0, 4'hF, 32'h0300_0000, 32'h0);
      wait_done(10, o);
      n_checks++; if (o.rdy !== 2'b01 || o.lat !== 3) begin n_fail++; $display("FAIL midreset_rr_first: ready=%b lat=%0d expected 01 3", o.rdy, o.lat); end
      step();
      m_req_i[0] = 1'b0;
      wait_done(10, o);
      n_checks++; if (o.rdy !== 2'b10 || o.lat !== 3) begin n_fail++; $display("FAIL midreset_rr_second: ready=%b lat=%0d expected 10 3", o.rdy, o.lat); end
      step();
      m_req_i[1] = 1'b0;
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      resetn_i  = 1'b0;
      m_req_i   = '0;
      m_we_i    = '0;
      m_be_i    = '0;
      m_addr_i  = '0;
      m_wd_i    = '0;
      s_ready_i = '0;
      s_rd_i    = '0;
      req_seen  = '0;
      resp_en   = 8'h09;
      for (int k = 0; k < 8; k++) slot_data[k] = 32'h0;
      slot_data[0] = 32'h1234_5678;
      slot_data[3] = 32'hCAFE_0003;

      test_reset();
      test_rr_pair();
      test_read();
      test_write();
      test_unmapped();
      test_timeout();
      test_back_to_back();
      test_reset_mid();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
